// File: rtl/i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target (slave) with a byte-wide register file. Decodes START, repeated
// START and STOP on synchronized SCL/SDA, matches a 7-bit device address and
// supports pointer-write, burst-write and burst-read with an auto-incrementing
// pointer. SDA is only ever pulled low through o_sda_oe (open drain); the pad
// wrapper does sda = o_sda_oe ? 1'b0 : 1'bz.
//
// Ports
//   i_clk         system clock, at least 8x the SCL frequency
//   i_rst         synchronous active-high reset
//   i_scl_in      SCL pin level (asynchronous)
//   i_sda_in      SDA pin level (asynchronous)
//   o_sda_oe      1 = pull SDA low, 0 = release
//   i_ack_en      0 = never acknowledge the address (absent device)
//   i_host_we     local write strobe into the register file
//   i_host_addr   local write/read address
//   i_host_wdata  local write data
//   o_host_rdata  regfile[i_host_addr], combinational
//   o_wr_valid    1-cycle pulse per data byte written over I2C
//   o_wr_addr     address of that byte
//   o_wr_data     data of that byte
//   o_busy        high from the matched address ACK until STOP or read NACK
// -----------------------------------------------------------------------------
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         AW          = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RST_VAL     = 8'h00
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_scl_in,
    input  logic          i_sda_in,
    output logic          o_sda_oe,
    input  logic          i_ack_en,
    input  logic          i_host_we,
    input  logic [AW-1:0] i_host_addr,
    input  logic [7:0]    i_host_wdata,
    output logic [7:0]    o_host_rdata,
    output logic          o_wr_valid,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RACK,
        S_WAIT_STOP
    } state_t;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    // ---------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    // Synchronizers idle high so reset never fabricates a START.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    // SCL must be high in both samples, so a SDA change coinciding with an
    // SCL edge is never mistaken for START/STOP.
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    // ---------------------------------------------------------------------
    // Protocol state
    // ---------------------------------------------------------------------
    state_t        r_state;
    logic [7:0]    r_shift;
    logic [3:0]    r_bitcnt;
    logic [AW-1:0] r_ptr;
    logic          r_rw;
    logic          r_sda_oe;
    logic          r_wr_valid;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_busy;

    logic [7:0]    r_mem [DEPTH];

    logic [7:0]    w_byte;
    logic          w_last_bit;
    logic          w_i2c_we;
    logic [7:0]    w_rd_byte;
    logic [AW-1:0] w_ptr_inc;

    // Byte as it stands once the current SDA sample is shifted in.
    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_last_bit = (r_bitcnt == 4'd7);
    assign w_i2c_we   = (r_state == S_WDATA) && w_scl_rise && w_last_bit;
    assign w_rd_byte  = r_mem[r_ptr];
    assign w_ptr_inc  = r_ptr + PTR_ONE;

    // ---------------------------------------------------------------------
    // Register file: the I2C write is placed last so it wins a same-address
    // collision with the host port; different addresses both land.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else begin
            if (i_host_we) begin
                r_mem[i_host_addr] <= i_host_wdata;
            end
            if (w_i2c_we) begin
                r_mem[r_ptr] <= w_byte;
            end
        end
    end

    assign o_host_rdata = r_mem[i_host_addr];

    // ---------------------------------------------------------------------
    // Transfer FSM. SDA drive changes only on SCL fall pulses. In the ACK
    // states, o_sda_oe itself marks the phase: the first fall asserts the
    // ACK, the second fall releases it and moves on.
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_shift    <= 8'h00;
            r_bitcnt   <= 4'd0;
            r_ptr      <= '0;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else if (w_start) begin
                // Any partial byte is simply discarded.
                r_state  <= S_ADDR;
                r_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_bitcnt <= 4'd0;
                                r_rw     <= w_sda;
                                if (w_byte[7:1] == DEV_ADDR && i_ack_en) begin
                                    r_state <= S_ADDR_ACK;
                                    r_busy  <= 1'b1;
                                end else begin
                                    r_state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else if (r_rw) begin
                                // Hand straight over to the first data bit.
                                r_state  <= S_RDATA;
                                r_shift  <= w_rd_byte;
                                r_sda_oe <= ~w_rd_byte[7];
                                r_bitcnt <= 4'd0;
                            end else begin
                                r_state  <= S_PTR;
                                r_sda_oe <= 1'b0;
                            end
                        end
                    end

                    S_PTR: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_bitcnt <= 4'd0;
                                r_ptr    <= w_byte[AW-1:0];
                                r_state  <= S_PTR_ACK;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_bitcnt   <= 4'd0;
                                r_wr_valid <= 1'b1;
                                r_wr_addr  <= r_ptr;
                                r_wr_data  <= w_byte;
                                r_ptr      <= w_ptr_inc;
                                r_state    <= S_WDATA_ACK;
                            end
                        end
                    end

                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_WDATA;
                            end
                        end
                    end

                    S_RDATA: begin
                        // r_shift[7] is the bit on the wire; advance after
                        // the controller has sampled it.
                        if (w_scl_rise) begin
                            r_shift  <= {r_shift[6:0], 1'b0};
                            r_bitcnt <= r_bitcnt + 4'd1;
                            if (w_last_bit) begin
                                r_ptr <= w_ptr_inc;
                            end
                        end else if (w_scl_fall) begin
                            if (r_bitcnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_bitcnt <= 4'd0;
                                r_state  <= S_RACK;
                            end else begin
                                r_sda_oe <= ~r_shift[7];
                            end
                        end
                    end

                    S_RACK: begin
                        if (w_scl_rise) begin
                            if (w_sda) begin
                                r_state <= S_WAIT_STOP;
                                r_busy  <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            r_state  <= S_RDATA;
                            r_shift  <= w_rd_byte;
                            r_sda_oe <= ~w_rd_byte[7];
                            r_bitcnt <= 4'd0;
                        end
                    end

                    default: begin
                        // IDLE and WAIT_STOP ignore SCL activity.
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_sda_oe   = r_sda_oe;
    assign o_wr_valid = r_wr_valid;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// -----------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Directed bench: a bit-banged I2C controller drives SCL/SDA over an
// open-drain wired-AND line. Expected register writes and read bytes are
// queued when stimulus is issued and popped when the target produces them.
// -----------------------------------------------------------------------------
module tb_i2c_target_regfile;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       m_scl;
    logic       m_sda;
    logic       ack_en;
    logic       host_we;
    logic [3:0] host_addr;
    logic [7:0] host_wdata;
    logic       sda_oe;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       sda_line;

    always #5 clk = ~clk;

    assign sda_line = m_sda & ~sda_oe;

    i2c_target_regfile #(
        .DEV_ADDR    (7'h50),
        .DEPTH       (16),
        .AW          (4),
        .SYNC_STAGES (2),
        .RST_VAL     (8'h00)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_scl_in     (m_scl),
        .i_sda_in     (sda_line),
        .o_sda_oe     (sda_oe),
        .i_ack_en     (ack_en),
        .i_host_we    (host_we),
        .i_host_addr  (host_addr),
        .i_host_wdata (host_wdata),
        .o_host_rdata (host_rdata),
        .o_wr_valid   (wr_valid),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy)
    );

    int         nchecks = 0;
    int         nerrors = 0;
    logic [11:0] wq[$];
    logic [7:0]  rq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock; optionally fire a host write in the exact cycle the
    // target commits a byte sampled on this rising edge.
    task automatic bitx(input logic b, input logic coll, input logic [3:0] ca,
                        input logic [7:0] cd, output logic s);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        if (coll) begin
            tick(2);
            host_addr  = ca;
            host_wdata = cd;
            host_we    = 1'b1;
            tick(1);
            host_we    = 1'b0;
            tick(Q - 3);
        end else begin
            tick(Q);
        end
        s = sda_line;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack, input logic coll,
                         input logic [3:0] ca, input logic [7:0] cd);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bitx(b[i], coll && (i == 0), ca, cd, s);
        end
        bitx(1'b1, 1'b0, 4'h0, 8'h00, ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic mack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bitx(1'b1, 1'b0, 4'h0, 8'h00, d[i]);
        end
        bitx(mack, 1'b0, 4'h0, 8'h00, s);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic peek(input string tag, input logic [3:0] a, input logic [7:0] exp);
        host_addr = a;
        tick(1);
        chk(tag, host_rdata, exp);
    endtask

    task automatic wr_exp(input string tag, input logic [7:0] b, input logic [3:0] a);
        logic ack;
        wq.push_back({a, b});
        wbyte(b, ack, 1'b0, 4'h0, 8'h00);
        chk(tag, ack, 1'b0);
    endtask

    task automatic rd_exp(input string tag, input logic [7:0] exp, input logic mack);
        logic [7:0] d;
        logic [7:0] e;
        rq.push_back(exp);
        rbyte(d, mack);
        e = rq.pop_front();
        chk(tag, d, e);
    endtask

    // Scoreboard for register-file writes reported by the target.
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            logic [11:0] e;
            if (wq.size() == 0) begin
                nchecks++;
                nerrors++;
                $error("FAIL wr_unexpected: observed addr %0h data %0h, expected no write",
                       wr_addr, wr_data);
            end else begin
                e = wq.pop_front();
                chk("wr_addr", wr_addr, e[11:8]);
                chk("wr_data", wr_data, e[7:0]);
            end
        end
    end

    initial begin
        logic a;
        logic [7:0] d;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; ack_en = 1'b1;
        host_we = 1'b0; host_addr = 4'h0; host_wdata = 8'h00;
        tick(5);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 4'h0);
        chk("rst_wr_data", wr_data, 8'h00);
        peek("rst_mem3", 4'h3, 8'h00);
        rst = 1'b0;
        tick(5);

        // T1: pointer write then burst write
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        chk("t1_addr_ack", a, 1'b0);
        chk("t1_busy", busy, 1'b1);
        wbyte(8'h03, a, 1'b0, 4'h0, 8'h00);
        chk("t1_ptr_ack", a, 1'b0);
        wr_exp("t1_d0_ack", 8'h5A, 4'h3);
        wr_exp("t1_d1_ack", 8'hC3, 4'h4);
        i2c_stop();
        tick(4);
        chk("t1_busy_stop", busy, 1'b0);
        peek("t1_mem3", 4'h3, 8'h5A);
        peek("t1_mem4", 4'h4, 8'hC3);

        // T2: pointer write, repeated START, burst read with ACK then NACK
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        chk("t2_addr_ack", a, 1'b0);
        wbyte(8'h03, a, 1'b0, 4'h0, 8'h00);
        chk("t2_ptr_ack", a, 1'b0);
        i2c_start();
        wbyte(8'hA1, a, 1'b0, 4'h0, 8'h00);
        chk("t2_raddr_ack", a, 1'b0);
        rd_exp("t2_rd0", 8'h5A, 1'b0);
        rd_exp("t2_rd1", 8'hC3, 1'b1);
        chk("t2_oe_after_nack", sda_oe, 1'b0);
        chk("t2_busy_after_nack", busy, 1'b0);
        wbyte(8'h00, a, 1'b0, 4'h0, 8'h00);
        chk("t2_wait_stop_noack", a, 1'b1);
        i2c_stop();

        // T3: wrong address, then absent device
        i2c_start();
        wbyte(8'h52, a, 1'b0, 4'h0, 8'h00);
        chk("t3_wrong_addr_nack", a, 1'b1);
        chk("t3_wrong_busy", busy, 1'b0);
        wbyte(8'h33, a, 1'b0, 4'h0, 8'h00);
        chk("t3_wrong_data_nack", a, 1'b1);
        i2c_stop();
        ack_en = 1'b0;
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        chk("t3_absent_nack", a, 1'b1);
        chk("t3_absent_busy", busy, 1'b0);
        wbyte(8'h44, a, 1'b0, 4'h0, 8'h00);
        chk("t3_absent_data_nack", a, 1'b1);
        i2c_stop();
        ack_en = 1'b1;

        // T4: pointer wrap; ack_en dropped mid-transfer has no effect
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        chk("t4_addr_ack", a, 1'b0);
        ack_en = 1'b0;
        wbyte(8'h0F, a, 1'b0, 4'h0, 8'h00);
        chk("t4_ptr_ack", a, 1'b0);
        wr_exp("t4_d0_ack", 8'h11, 4'hF);
        wr_exp("t4_d1_ack", 8'h22, 4'h0);
        i2c_stop();
        ack_en = 1'b1;
        peek("t4_mem15", 4'hF, 8'h11);
        peek("t4_mem0", 4'h0, 8'h22);
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        wbyte(8'hF3, a, 1'b0, 4'h0, 8'h00);
        chk("t4_ptrF3_ack", a, 1'b0);
        wr_exp("t4_d2_ack", 8'h99, 4'h3);
        i2c_stop();
        peek("t4_mem3", 4'h3, 8'h99);

        // T5: STOP after 4 data bits, then same-cycle host/I2C collisions
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        wbyte(8'h05, a, 1'b0, 4'h0, 8'h00);
        bitx(1'b1, 1'b0, 4'h0, 8'h00, a);
        bitx(1'b0, 1'b0, 4'h0, 8'h00, a);
        bitx(1'b1, 1'b0, 4'h0, 8'h00, a);
        bitx(1'b0, 1'b0, 4'h0, 8'h00, a);
        i2c_stop();
        tick(4);
        chk("t5_abort_busy", busy, 1'b0);
        peek("t5_abort_mem5", 4'h5, 8'h00);
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        wbyte(8'h04, a, 1'b0, 4'h0, 8'h00);
        wq.push_back({4'h4, 8'hE1});
        wbyte(8'hE1, a, 1'b1, 4'h4, 8'h3C);
        chk("t5_coll_same_ack", a, 1'b0);
        wq.push_back({4'h5, 8'h7E});
        wbyte(8'h7E, a, 1'b1, 4'h9, 8'h96);
        chk("t5_coll_diff_ack", a, 1'b0);
        i2c_stop();
        peek("t5_coll_mem4", 4'h4, 8'hE1);
        peek("t5_coll_mem9", 4'h9, 8'h96);
        peek("t5_coll_mem5", 4'h5, 8'h7E);

        // T6: reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            d = 8'hA0;
            bitx(d[i], 1'b0, 4'h0, 8'h00, a);
        end
        m_sda = 1'b1;
        chk("t6_oe_before_rst", sda_oe, 1'b1);
        rst = 1'b1;
        tick(1);
        chk("t6_oe_after_rst", sda_oe, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        rst = 1'b0;
        tick(3);
        peek("t6_mem3_rstval", 4'h3, 8'h00);
        i2c_start();
        wbyte(8'hA0, a, 1'b0, 4'h0, 8'h00);
        chk("t6_addr_ack", a, 1'b0);
        wbyte(8'h07, a, 1'b0, 4'h0, 8'h00);
        wr_exp("t6_d0_ack", 8'h5C, 4'h7);
        i2c_stop();
        peek("t6_mem7", 4'h7, 8'h5C);

        tick(4);
        chk("wq_empty", wq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
